alarm_ctrl: RTL and testbench

Alarm controller directly downstream of the `clock` timekeeping block. It consumes the running hour/minute/second and holds a user-settable alarm time. A ring/snooze state machine drives the buzzer/LED `ringing` output. Sits between `clock` and the board I/O (buttons in, buzzer and display out).

---
 rtl/alarm_pkg.sv | 15 +
 rtl/sec_tick_det.sv | 21 ++
 rtl/alarm_ctrl.sv | 127 ++++++++++++
 tb/tb_alarm_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller and its helpers.
package alarm_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRing   = 2'd1,
        StSnooze = 2'd2
    } state_t;

    localparam logic [5:0] HourMax = 6'd23;
    localparam logic [5:0] MinMax  = 6'd59;

    localparam int unsigned CntWidth = 12;

endpackage

// File: rtl/sec_tick_det.sv
// Registers the incoming seconds value and flags each cycle where it has changed.
module sec_tick_det (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] second,
    output logic       sec_tick
);

    logic [5:0] second_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            second_q <= '0;
        end else begin
            second_q <= second;
        end
    end

    assign sec_tick = (second != second_q);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: user-set alarm time plus ring/snooze state machine driving the buzzer.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       arm,
    input  logic       set_en,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       snooze,
    input  logic       stop,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       ringing,
    output logic [1:0] state
);

    localparam logic [CntWidth-1:0] CntOne     = 1;
    localparam logic [CntWidth-1:0] RingLast   = CntWidth'(RING_SECS - 1);
    localparam logic [CntWidth-1:0] SnoozeLast = CntWidth'(SNOOZE_SECS - 1);

    logic                sec_tick;
    logic                match;
    state_t              state_q, state_d;
    logic [CntWidth-1:0] ring_cnt_q, ring_cnt_d;
    logic [CntWidth-1:0] snooze_cnt_q, snooze_cnt_d;
    logic [5:0]          alarm_hour_q, alarm_hour_d;
    logic [5:0]          alarm_minute_q, alarm_minute_d;
    logic                ringing_q;

    sec_tick_det u_sec_tick_det (
        .clk      (clk),
        .rst      (rst),
        .second   (second),
        .sec_tick (sec_tick)
    );

    assign match = sec_tick && (second == 6'd0) && (hour == alarm_hour_q) &&
                   (minute == alarm_minute_q) && arm && !set_en;

    always_comb begin
        alarm_hour_d   = alarm_hour_q;
        alarm_minute_d = alarm_minute_q;
        if (set_en) begin
            if (inc_hour) begin
                alarm_hour_d = (alarm_hour_q == HourMax) ? 6'd0 : alarm_hour_q + 6'd1;
            end
            if (inc_min) begin
                alarm_minute_d = (alarm_minute_q == MinMax) ? 6'd0 : alarm_minute_q + 6'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (match) begin
                    state_d    = StRing;
                    ring_cnt_d = '0;
                end
            end
            StRing: begin
                if (sec_tick) begin
                    ring_cnt_d = ring_cnt_q + CntOne;
                end
                if (stop) begin
                    state_d = StIdle;
                end else if (snooze) begin
                    state_d      = StSnooze;
                    snooze_cnt_d = '0;
                end else if (sec_tick && (ring_cnt_q == RingLast)) begin
                    state_d = StIdle;
                end
            end
            StSnooze: begin
                if (sec_tick) begin
                    snooze_cnt_d = snooze_cnt_q + CntOne;
                end
                if (stop) begin
                    state_d = StIdle;
                end else if (sec_tick && (snooze_cnt_q == SnoozeLast)) begin
                    state_d    = StRing;
                    ring_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        // Disarming overrides every other event, including the illegal-state recovery.
        if (!arm) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            ring_cnt_q     <= '0;
            snooze_cnt_q   <= '0;
            alarm_hour_q   <= '0;
            alarm_minute_q <= '0;
            ringing_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ring_cnt_q     <= ring_cnt_d;
            snooze_cnt_q   <= snooze_cnt_d;
            alarm_hour_q   <= alarm_hour_d;
            alarm_minute_q <= alarm_minute_d;
            ringing_q      <= (state_d == StRing);
        end
    end

    assign alarm_hour   = alarm_hour_q;
    assign alarm_minute = alarm_minute_q;
    assign ringing      = ringing_q;
    assign state        = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with default RING_SECS/SNOOZE_SECS.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] hour = '0;
    logic [5:0] minute = '0;
    logic [5:0] second = '0;
    logic       arm = 1'b0;
    logic       set_en = 1'b0;
    logic       inc_hour = 1'b0;
    logic       inc_min = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       ringing;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int h_t = 0;
    int m_t = 0;
    int s_t = 0;

    alarm_ctrl #(
        .RING_SECS   (60),
        .SNOOZE_SECS (300)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hour         (hour),
        .minute       (minute),
        .second       (second),
        .arm          (arm),
        .set_en       (set_en),
        .inc_hour     (inc_hour),
        .inc_min      (inc_min),
        .snooze       (snooze),
        .stop         (stop),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute),
        .ringing      (ringing),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        h_t = h;
        m_t = m;
        s_t = s;
        hour = 6'(h);
        minute = 6'(m);
        second = 6'(s);
        step();
        step();
    endtask

    // One second change; held for two cycles so only the first sees a tick.
    task automatic tick();
        s_t++;
        if (s_t == 60) begin
            s_t = 0;
            m_t++;
            if (m_t == 60) begin
                m_t = 0;
                h_t = (h_t + 1) % 24;
            end
        end
        hour = 6'(h_t);
        minute = 6'(m_t);
        second = 6'(s_t);
        step();
        step();
    endtask

    task automatic pulse(input logic ph, input logic pm, input logic ps, input logic pt);
        inc_hour = ph;
        inc_min = pm;
        snooze = ps;
        stop = pt;
        step();
        inc_hour = 1'b0;
        inc_min = 1'b0;
        snooze = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_alarm_hour", {26'b0, alarm_hour}, 32'd0);
        check("rst_alarm_minute", {26'b0, alarm_minute}, 32'd0);
        check("rst_ringing", {31'b0, ringing}, 32'd0);
        check("rst_state", {30'b0, state}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Set 07:30; one cycle with both pulses advances hour and minute together.
        set_en = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("inc_hour_latency", {26'b0, alarm_hour}, 32'd1);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("both_hour", {26'b0, alarm_hour}, 32'd7);
        check("both_minute", {26'b0, alarm_minute}, 32'd1);
        for (int i = 0; i < 29; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("set_minute", {26'b0, alarm_minute}, 32'd30);
        set_en = 1'b0;
        arm = 1'b1;

        // Match and automatic timeout after 60 ticks.
        set_time(7, 29, 59);
        check("pre_match_ringing", {31'b0, ringing}, 32'd0);
        hour = 6'd7;
        minute = 6'd30;
        second = 6'd0;
        h_t = 7;
        m_t = 30;
        s_t = 0;
        step();
        check("match_ringing", {31'b0, ringing}, 32'd1);
        check("match_state", {30'b0, state}, 32'd1);
        for (int i = 0; i < 59; i++) tick();
        check("ring_59_ticks", {31'b0, ringing}, 32'd1);
        tick();
        check("ring_timeout_ringing", {31'b0, ringing}, 32'd0);
        check("ring_timeout_state", {30'b0, state}, 32'd0);

        // Snooze, re-ring after 300 ticks, then stop.
        set_time(7, 29, 59);
        tick();
        check("ring2_state", {30'b0, state}, 32'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("snooze_state", {30'b0, state}, 32'd2);
        check("snooze_ringing", {31'b0, ringing}, 32'd0);
        for (int i = 0; i < 299; i++) tick();
        check("snooze_299_state", {30'b0, state}, 32'd2);
        tick();
        check("rering_ringing", {31'b0, ringing}, 32'd1);
        check("rering_state", {30'b0, state}, 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("stop_state", {30'b0, state}, 32'd0);

        // stop beats snooze in the same cycle.
        set_time(7, 29, 59);
        tick();
        check("ring3_state", {30'b0, state}, 32'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("stop_snooze_state", {30'b0, state}, 32'd0);

        // Disarm while snoozing.
        set_time(7, 29, 59);
        tick();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("snooze2_state", {30'b0, state}, 32'd2);
        arm = 1'b0;
        step();
        check("disarm_state", {30'b0, state}, 32'd0);
        arm = 1'b1;

        // Edit wraps and ignored pulses.
        set_en = 1'b1;
        for (int i = 0; i < 29; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("min_at_59", {26'b0, alarm_minute}, 32'd59);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("min_wrap", {26'b0, alarm_minute}, 32'd0);
        check("min_wrap_hour", {26'b0, alarm_hour}, 32'd7);
        for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("hour_at_23", {26'b0, alarm_hour}, 32'd23);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("hour_wrap", {26'b0, alarm_hour}, 32'd0);
        set_en = 1'b0;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("locked_hour", {26'b0, alarm_hour}, 32'd0);
        check("locked_minute", {26'b0, alarm_minute}, 32'd0);

        // Match time with set_en=1, then with arm=0: no ring.
        set_en = 1'b1;
        set_time(23, 59, 59);
        tick();
        check("no_ring_set_en", {31'b0, ringing}, 32'd0);
        set_en = 1'b0;
        arm = 1'b0;
        set_time(23, 59, 59);
        tick();
        check("no_ring_disarmed", {31'b0, ringing}, 32'd0);
        arm = 1'b1;

        // Asynchronous reset mid-ring with a nonzero alarm time.
        set_en = 1'b1;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        set_en = 1'b0;
        set_time(1, 1, 59);
        tick();
        check("ring4_ringing", {31'b0, ringing}, 32'd1);
        check("ring4_alarm_minute", {26'b0, alarm_minute}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ringing", {31'b0, ringing}, 32'd0);
        check("async_rst_hour", {26'b0, alarm_hour}, 32'd0);
        check("async_rst_minute", {26'b0, alarm_minute}, 32'd0);
        check("async_rst_state", {30'b0, state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
